// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the I/D-cache to pmem line-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_arbiter_pkg;

  typedef logic [127:0] lc3b_c_line;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_CLIENT_I = 1'b0,
    ARB_CLIENT_D = 1'b1
  } arb_client_t;

  // Arbitration mode selector values for ARB_MODE.
  localparam int ARB_RR   = 0;
  localparam int ARB_DPRI = 1;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and pmem line-port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests held until the matching resp; pmem_resp is a one-cycle pulse.
// Modports: slave = arbiter side, master = client caches and pmem side.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);

  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_arbiter_arb_grant.sv
// Combinational winner select between the I-cache and D-cache requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only acts on winner while gnt_vld is high.
// Ports: req_i/req_d requests, last_grant previous winner, gnt_vld any request, winner chosen client.
module cache_arbiter_arb_grant
  import cache_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic        req_i,
  input  logic        req_d,
  input  arb_client_t last_grant,
  output logic        gnt_vld,
  output arb_client_t winner
);

  always_comb begin
    gnt_vld = req_i | req_d;
    winner  = ARB_CLIENT_I;
    if (req_i && req_d) begin
      if (ARB_MODE == ARB_DPRI) begin
        winner = ARB_CLIENT_D;
      end else begin
        // Round-robin: whoever did not win last time goes next.
        winner = (last_grant == ARB_CLIENT_I) ? ARB_CLIENT_D : ARB_CLIENT_I;
      end
    end else if (req_d) begin
      winner = ARB_CLIENT_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem line port between the I-cache and D-cache, one transaction at a time.
// Latency: strobe 1 cycle after request sampled in idle; client resp same cycle as pmem_resp.
// Backpressure: the loser keeps its request high; at least one idle cycle between transactions.
// Ports: clk, reset (async, active-low), bus (slave modport: client requests/responses + pmem port).
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int ARB_MODE   = ARB_RR
) (
  input  logic          clk,
  input  logic          reset,
  cache_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = ARB_IDLE;
  localparam logic [1:0] ST_SERVE_I = ARB_SERVE_I;
  localparam logic [1:0] ST_SERVE_D = ARB_SERVE_D;

  logic [1:0]            state;
  arb_client_t           last_grant;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic                  lat_write;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;

  logic        req_i;
  logic        req_d;
  logic        gnt_vld;
  arb_client_t winner;
  logic        i_done;
  logic        d_done;

  assign req_i = bus.i_pmem_read;
  assign req_d = bus.d_pmem_read | bus.d_pmem_write;

  cache_arbiter_arb_grant #(
    .ARB_MODE (ARB_MODE)
  ) u_arb_grant (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= ARB_CLIENT_I;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // pmem_resp seen here is spurious and deliberately ignored.
          if (gnt_vld) begin
            last_grant <= winner;
            if (winner == ARB_CLIENT_D) begin
              state     <= ST_SERVE_D;
              lat_addr  <= bus.d_pmem_address;
              lat_wdata <= bus.d_pmem_wdata;
              // Read+write together is illegal; the writeback wins.
              lat_write <= bus.d_pmem_write;
            end else begin
              state     <= ST_SERVE_I;
              lat_addr  <= bus.i_pmem_address;
              lat_wdata <= '0;
              lat_write <= 1'b0;
            end
          end
        end
        ST_SERVE_I: begin
          if (bus.pmem_resp) begin
            state     <= ST_IDLE;
            i_rdata_q <= bus.pmem_rdata;
          end
        end
        ST_SERVE_D: begin
          if (bus.pmem_resp) begin
            state     <= ST_IDLE;
            d_rdata_q <= bus.pmem_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes come only from state and latched op, so client-side changes after
  // grant never reach pmem, and async reset drops them immediately.
  assign bus.pmem_read    = (state != ST_IDLE) && !lat_write;
  assign bus.pmem_write   = (state != ST_IDLE) && lat_write;
  assign bus.pmem_address = lat_addr;
  assign bus.pmem_wdata   = lat_wdata;

  assign i_done = (state == ST_SERVE_I) && bus.pmem_resp;
  assign d_done = (state == ST_SERVE_D) && bus.pmem_resp;

  // rdata passes through on the completion cycle and otherwise holds the last line.
  assign bus.i_pmem_resp  = i_done;
  assign bus.d_pmem_resp  = d_done;
  assign bus.i_pmem_rdata = i_done ? bus.pmem_rdata : i_rdata_q;
  assign bus.d_pmem_rdata = d_done ? bus.pmem_rdata : d_rdata_q;

  d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (!reset) !(bus.d_pmem_read && bus.d_pmem_write)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mode;
  logic       c_i_read;
  lc3b_word   c_i_addr;
  logic       c_d_read;
  logic       c_d_write;
  lc3b_word   c_d_addr;
  lc3b_c_line c_d_wdata;
  lc3b_c_line c_prdata;
  logic       c_presp;

  int total = 0;
  int bad   = 0;

  cache_arbiter_if #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) b0 ();
  cache_arbiter_if #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) b1 ();

  // Only the DUT selected by mode sees live requests; the other stays idle.
  assign b0.i_pmem_read    = c_i_read  & ~mode;
  assign b0.d_pmem_read    = c_d_read  & ~mode;
  assign b0.d_pmem_write   = c_d_write & ~mode;
  assign b0.pmem_resp      = c_presp   & ~mode;
  assign b0.i_pmem_address = c_i_addr;
  assign b0.d_pmem_address = c_d_addr;
  assign b0.d_pmem_wdata   = c_d_wdata;
  assign b0.pmem_rdata     = c_prdata;

  assign b1.i_pmem_read    = c_i_read  & mode;
  assign b1.d_pmem_read    = c_d_read  & mode;
  assign b1.d_pmem_write   = c_d_write & mode;
  assign b1.pmem_resp      = c_presp   & mode;
  assign b1.i_pmem_address = c_i_addr;
  assign b1.d_pmem_address = c_d_addr;
  assign b1.d_pmem_wdata   = c_d_wdata;
  assign b1.pmem_rdata     = c_prdata;

  cache_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(16), .ARB_MODE(ARB_RR)) u_rr (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b0)
  );

  cache_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(16), .ARB_MODE(ARB_DPRI)) u_dpri (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b1)
  );

  logic       o_pread, o_pwrite, o_iresp, o_dresp;
  lc3b_word   o_paddr;
  lc3b_c_line o_pwdata, o_ird, o_drd;
  assign o_pread  = mode ? b1.pmem_read    : b0.pmem_read;
  assign o_pwrite = mode ? b1.pmem_write   : b0.pmem_write;
  assign o_paddr  = mode ? b1.pmem_address : b0.pmem_address;
  assign o_pwdata = mode ? b1.pmem_wdata   : b0.pmem_wdata;
  assign o_iresp  = mode ? b1.i_pmem_resp  : b0.i_pmem_resp;
  assign o_dresp  = mode ? b1.d_pmem_resp  : b0.d_pmem_resp;
  assign o_ird    = mode ? b1.i_pmem_rdata : b0.i_pmem_rdata;
  assign o_drd    = mode ? b1.d_pmem_rdata : b0.d_pmem_rdata;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Transaction-level model: at most one open transaction; a new one opens on
  // any clock with no open transaction and a pending request.
  logic       m_open, m_for_d, m_is_wr, m_last_d;
  lc3b_word   m_addr;
  lc3b_c_line m_wdata, m_ird, m_drd;

  always @(posedge clk or negedge rst_n) begin : model
    logic want_i, want_d, d_wins;
    if (!rst_n) begin
      m_open = 1'b0; m_for_d = 1'b0; m_is_wr = 1'b0; m_last_d = 1'b0;
      m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
    end else if (m_open) begin
      if (c_presp) begin
        m_open = 1'b0;
        if (m_for_d) m_drd = c_prdata;
        else         m_ird = c_prdata;
      end
    end else begin
      want_i = c_i_read;
      want_d = c_d_read | c_d_write;
      if (want_i || want_d) begin
        d_wins   = want_d && (!want_i || mode || !m_last_d);
        m_open   = 1'b1;
        m_for_d  = d_wins;
        m_last_d = d_wins;
        m_addr   = d_wins ? c_d_addr : c_i_addr;
        m_is_wr  = d_wins && c_d_write;
        m_wdata  = c_d_wdata;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic ei, ed;
    ei = m_open && !m_for_d && c_presp;
    ed = m_open &&  m_for_d && c_presp;
    chk("m_pmem_read",  o_pread,  m_open && !m_is_wr);
    chk("m_pmem_write", o_pwrite, m_open &&  m_is_wr);
    chk("m_i_resp",     o_iresp,  ei);
    chk("m_d_resp",     o_dresp,  ed);
    chk("m_i_rdata",    o_ird,    ei ? c_prdata : m_ird);
    chk("m_d_rdata",    o_drd,    ed ? c_prdata : m_drd);
    if (m_open) chk("m_pmem_address", o_paddr, m_addr);
    if (m_open && m_is_wr) chk("m_pmem_wdata", o_pwdata, m_wdata);
  end

  // Log the pmem address at every rising strobe to pin grant order.
  lc3b_word glog[$];
  logic     prev_stb = 1'b0;
  always @(negedge clk) begin
    if ((o_pread || o_pwrite) && !prev_stb) glog.push_back(o_paddr);
    prev_stb = o_pread || o_pwrite;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0;
    c_i_read = 1'b0; c_d_read = 1'b0; c_d_write = 1'b0; c_presp = 1'b0;
    c_i_addr = '0; c_d_addr = '0; c_d_wdata = '0; c_prdata = '0;
    mode = m;
    #1;
    chk("rst_pmem_read",  o_pread,  0);
    chk("rst_pmem_write", o_pwrite, 0);
    chk("rst_pmem_addr",  o_paddr,  0);
    chk("rst_i_resp",     o_iresp,  0);
    chk("rst_d_resp",     o_dresp,  0);
    chk("rst_i_rdata",    o_ird,    0);
    chk("rst_d_rdata",    o_drd,    0);
    tick(2);
    rst_n = 1'b1;
    glog.delete();
  endtask

  // Wait (bounded) for a strobe, let lat cycles pass, then pulse pmem_resp once.
  task automatic respond(input int lat, input lc3b_c_line data, input logic to_d);
    int k;
    k = 0;
    while (!(o_pread || o_pwrite) && k < 20) begin
      tick(1);
      k++;
    end
    chk("strobe_seen", o_pread || o_pwrite, 1);
    repeat (lat) tick(1);
    c_prdata = data;
    c_presp  = 1'b1;
    #1;
    chk("resp_i", o_iresp, !to_d);
    chk("resp_d", o_dresp, to_d);
    if (to_d) chk("rdata_d", o_drd, data);
    else      chk("rdata_i", o_ird, data);
    tick(1);
    c_presp = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  initial begin : stim
    lc3b_word a;
    lc3b_c_line l1, la5;
    l1  = {4{32'h1111_2222}};
    la5 = {16{8'hA5}};

    // Only I reads 0x0040, resp 3 cycles after strobe.
    do_reset(1'b0);
    c_i_read = 1'b1; c_i_addr = 16'h0040;
    tick(1);
    chk("t1_read",  o_pread, 1);
    chk("t1_addr",  o_paddr, 16'h0040);
    chk("t1_write", o_pwrite, 0);
    respond(3, l1, 1'b0);
    c_i_read = 1'b0;
    tick(1);
    chk("t1_idle",  o_pread, 0);
    chk("t1_hold",  o_ird, l1);
    chk("t1_dresp", o_dresp, 0);

    // Round-robin, simultaneous from reset: D first, I one cycle after D's resp.
    do_reset(1'b0);
    c_i_read = 1'b1; c_i_addr = 16'h0080;
    c_d_read = 1'b1; c_d_addr = 16'h1000;
    tick(1);
    chk("t2_first_addr", o_paddr, 16'h1000);
    respond(1, {4{32'hDDDD_0001}}, 1'b1);
    c_d_read = 1'b0;
    chk("t2_gap", o_pread, 0);
    tick(1);
    chk("t2_i_read", o_pread, 1);
    chk("t2_i_addr", o_paddr, 16'h0080);
    respond(1, {4{32'h1111_0002}}, 1'b0);
    c_i_read = 1'b0;
    tick(2);
    chk("t2_ngrants", glog.size(), 2);
    chk("t2_g0", glog[0], 16'h1000);
    chk("t2_g1", glog[1], 16'h0080);

    // Fixed D priority: continuous D starves I until D stops.
    do_reset(1'b1);
    c_i_read = 1'b1; c_i_addr = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      a = 16'h1000 + 16'(k * 16);
      c_d_read = 1'b1; c_d_addr = a;
      respond(0, {4{32'hD000_0000 + 32'(k)}}, 1'b1);
    end
    c_d_read = 1'b0;
    respond(0, {4{32'h1111_0003}}, 1'b0);
    c_i_read = 1'b0;
    tick(2);
    chk("t3_ngrants", glog.size(), 4);
    chk("t3_g0", glog[0], 16'h1000);
    chk("t3_g1", glog[1], 16'h1010);
    chk("t3_g2", glog[2], 16'h1020);
    chk("t3_g3", glog[3], 16'h0040);

    // Writeback with client inputs changed after grant; then fill, I served between.
    do_reset(1'b0);
    c_d_write = 1'b1; c_d_addr = 16'h2000; c_d_wdata = la5;
    tick(1);
    chk("t4_write", o_pwrite, 1);
    chk("t4_read",  o_pread, 0);
    chk("t4_addr",  o_paddr, 16'h2000);
    chk("t4_wdata", o_pwdata, la5);
    c_d_addr = 16'h3000; c_d_wdata = '0;
    c_i_read = 1'b1; c_i_addr = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t4_hold_write", o_pwrite, 1);
      chk("t4_hold_addr",  o_paddr, 16'h2000);
      chk("t4_hold_wdata", o_pwdata, la5);
    end
    respond(0, {4{32'h0000_0004}}, 1'b1);
    c_d_write = 1'b0; c_d_read = 1'b1;
    tick(1);
    chk("t4_i_between", o_paddr, 16'h0040);
    respond(0, {4{32'h1111_0004}}, 1'b0);
    c_i_read = 1'b0;
    respond(0, {4{32'hDDDD_0004}}, 1'b1);
    c_d_read = 1'b0;
    tick(2);
    chk("t4_ngrants", glog.size(), 3);
    chk("t4_g0", glog[0], 16'h2000);
    chk("t4_g1", glog[1], 16'h0040);
    chk("t4_g2", glog[2], 16'h3000);

    // Reset mid-transaction: strobes drop at once, no resp, re-arbitrate after release.
    do_reset(1'b0);
    c_d_read = 1'b1; c_d_addr = 16'h1000;
    tick(2);
    chk("t5_busy", o_pread, 1);
    rst_n = 1'b0;
    c_prdata = {4{32'hBAD0_BAD0}}; c_presp = 1'b1;
    #1;
    chk("t5_read_drop",  o_pread, 0);
    chk("t5_write_drop", o_pwrite, 0);
    chk("t5_no_iresp",   o_iresp, 0);
    chk("t5_no_dresp",   o_dresp, 0);
    chk("t5_d_rdata",    o_drd, 0);
    c_i_read = 1'b1; c_i_addr = 16'h0040;
    tick(1);
    c_presp = 1'b0;
    rst_n = 1'b1;
    glog.delete();
    tick(1);
    chk("t5_regrant_read", o_pread, 1);
    chk("t5_regrant_addr", o_paddr, 16'h1000);
    respond(0, {4{32'hDDDD_0005}}, 1'b1);
    c_d_read = 1'b0;
    respond(0, {4{32'h1111_0005}}, 1'b0);
    c_i_read = 1'b0;
    tick(2);
    chk("t5_ngrants", glog.size(), 2);

    // Spurious pmem_resp while idle.
    c_prdata = {4{32'h5555_AAAA}}; c_presp = 1'b1;
    #1;
    chk("t6_no_iresp", o_iresp, 0);
    chk("t6_no_dresp", o_dresp, 0);
    tick(1);
    c_presp = 1'b0;
    chk("t6_idle", o_pread || o_pwrite, 0);
    chk("t6_i_rdata_kept", o_ird, {4{32'h1111_0005}});
    c_i_read = 1'b1; c_i_addr = 16'h0050;
    tick(1);
    chk("t6_grant_read", o_pread, 1);
    chk("t6_grant_addr", o_paddr, 16'h0050);
    respond(2, {4{32'h1111_0006}}, 1'b0);
    c_i_read = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
